stack_arbiter: RTL and testbench
================================

# stack_arbiter

Two-client arbiter and sequencer for the 5-entry, 4-bit stack. Accepts push/pop/get requests from two requesters over a req/ack handshake, checks them against a tracked occupancy count, and drives exactly one stack command per granted request. Rejects overflow, underflow and out-of-range gets without touching the stack, and returns read data to the winning requester. Sits between the client logic and the stack, and owns the stack's COMMAND, INDEX and write-data drive.

## Interface
Parameters:
- DEPTH, 5, stack entries; occupancy range 0..DEPTH
- DW, 4, data width
- IW, 3, index/count width

Ports:
- CLK  in  1  single clock, all state on rising edge
- RESET  in  1  asynchronous, active-high; also drives the stack's RESET
- req  in  2  per-client request, held high until ack
- cmd0, cmd1  in  2 each  client command: 00 nop, 01 push, 10 pop, 11 get
- idx0, idx1  in  IW each  get index, 0 = top of stack
- wdata0, wdata1  in  DW each  push data
- ack  out  2  one-cycle completion pulse per client
- err  out  1  valid with ack; 1 = request rejected
- rdata  out  DW  pop/get result, valid with ack
- stk_cmd  out  2  command to stack
- stk_index  out  IW  index to stack
- stk_wdata  out  DW  push data to stack
- stk_wdata_oe  out  1  enables write-data drive onto the stack data bus
- stk_rdata  in  DW  stack read data
- count  out  IW  current occupancy
- full, empty  out  1  count==DEPTH, count==0

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE: if any req is high, pick a winner, latch its cmd/idx/wdata and its id, then check legality:
  - push requires count<DEPTH
  - pop requires count>0
  - get requires idx<count
  - nop is always legal but has no stack access
  - A legal non-nop request goes to ISSUE. Nop or illegal goes to RESP with err=(illegal).
- ISSUE: stk_cmd = latched command, stk_index = latched idx (get only, else 0). stk_wdata_oe=1 only for push. Exactly one cycle. At its end, count +1 on push, -1 on pop, and stk_rdata is captured into rdata for pop/get.
- RESP: ack[id]=1, err valid, rdata valid (0 for push, nop, error). Next state IDLE.
- In all non-ISSUE cycles: stk_cmd=00, stk_wdata_oe=0.
- A requester that holds req high through the ack cycle starts a new transaction at the next IDLE.
- Request inputs are ignored outside IDLE. A req withdrawn before grant is dropped silently.
- Count never leaves 0..DEPTH. An illegal request never changes count or the stack.

## Timing
- Reset (async): state IDLE, count=0, empty=1, full=0, ack=0, err=0, rdata=0, stk_cmd=00, stk_index=0, stk_wdata=0, stk_wdata_oe=0, round-robin pointer favours client 0.
- Legal op: req sampled in IDLE at edge N; stk_cmd active in cycle N..N+1; ack high in cycle N+1..N+2. Latency is 2 cycles and throughput is one op per 3 cycles.
- Illegal op or nop: ack one cycle after grant (latency 1), followed by 1 IDLE cycle.
- Simultaneous req from both clients: one is granted and the other waits in IDLE for the next decision. No request is lost while it is held high.
- RESET during ISSUE: the stack command is aborted, no ack is issued, count returns to 0, and the stack is cleared by the same RESET.

## Configuration
- STACK_ARB_RR_EN defined: round-robin. When both clients request, the client not granted last wins. The pointer updates on every grant.
- Undefined: fixed priority, client 0 always wins. A continuously requesting client 0 can starve client 1; this is accepted.

## Structure
- Package stack_pkg:
  - command enum CMD_NOP/CMD_PUSH/CMD_POP/CMD_GET
  - state enum IDLE/ISSUE/RESP
  - DEPTH/DW/IW defaults
- Sub-module stack_arb_rr: 2-way grant logic with pointer register, including the STACK_ARB_RR_EN switch. FSM, legality checks and count live in stack_arbiter.

## Test plan
- After reset, client 0 pushes 4'hA, 4'h3 -> two acks with err=0, count=2, stk_wdata_oe high only in ISSUE cycles.
- Pop on empty -> ack after 1 cycle, err=1, count stays 0, stk_cmd stays 00 throughout.
- Push 1,2,3,4,5 then a 6th push -> 6th gives err=1, full=1. A following get idx=4 returns rdata=1. A get idx=5 gives err=1.
- Both clients request continuously with STACK_ARB_RR_EN -> acks alternate 0,1,0,1. Without the macro -> only client 0 is acked.
- Push 7, push 9, then pop -> rdata=9 and count=1. The next pop gives rdata=7, empty=1.
- Assert RESET in the ISSUE cycle of a push with count=3 -> no ack, all outputs return to reset values immediately, count=0.

Source files
------------

// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared types and default sizes for the stack arbiter slice
package stack_pkg;

  localparam int DEF_DEPTH = 5;
  localparam int DEF_DW    = 4;
  localparam int DEF_IW    = 3;

  typedef enum logic [1:0] {
    CMD_NOP  = 2'b00,
    CMD_PUSH = 2'b01,
    CMD_POP  = 2'b10,
    CMD_GET  = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    RESP  = 2'b10
  } state_e;

endpackage

// File: rtl/stack_arb_rr.sv
// rtl/stack_arb_rr.sv - 2-way grant logic; STACK_ARB_RR_EN selects round-robin over fixed priority
module stack_arb_rr (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       gnt_id,
  output logic       gnt_valid
);

  // ptr names the client that wins a tie; 0 after reset
  logic ptr;
  logic ptr_next;

  // tie-break pointer register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) ptr <= 1'b0;
    else       ptr <= ptr_next;
  end

  // winner: a lone requester wins, a tie goes to the pointer
  always_comb begin
    gnt_valid = |req;
    gnt_id    = (req == 2'b11) ? ptr : req[1];
  end

  // pointer update on each accepted grant
  always_comb begin
`ifdef STACK_ARB_RR_EN
    ptr_next = advance ? ~gnt_id : ptr;
`else
    // fixed priority: the pointer stays pinned to client 0
    ptr_next = advance ? 1'b0 : ptr;
`endif
  end

endmodule

// File: rtl/stack_arbiter.sv
// rtl/stack_arbiter.sv - two-client req/ack sequencer for the stack; STACK_ARB_RR_EN enables round-robin
module stack_arbiter
  import stack_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int DW    = DEF_DW,
  parameter int IW    = DEF_IW
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [1:0]    req,
  input  logic [1:0]    cmd0,
  input  logic [1:0]    cmd1,
  input  logic [IW-1:0] idx0,
  input  logic [IW-1:0] idx1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic [1:0]    ack,
  output logic          err,
  output logic [DW-1:0] rdata,
  output logic [1:0]    stk_cmd,
  output logic [IW-1:0] stk_index,
  output logic [DW-1:0] stk_wdata,
  output logic          stk_wdata_oe,
  input  logic [DW-1:0] stk_rdata,
  output logic [IW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam logic [IW-1:0] DEPTH_C = IW'(DEPTH);
  localparam logic [IW-1:0] ONE_C   = IW'(1);

  state_e        state;
  state_e        state_next;

  logic          gnt_id;
  logic          gnt_valid;
  logic          take;

  cmd_e          sel_cmd;
  logic [IW-1:0] sel_idx;
  logic [DW-1:0] sel_wdata;
  logic          sel_legal;

  logic          lat_id;
  cmd_e          lat_cmd;
  logic [IW-1:0] lat_idx;
  logic [DW-1:0] lat_wdata;
  logic          err_q;
  logic [DW-1:0] rdata_q;
  logic [IW-1:0] count_q;

  assign take = (state == IDLE) && gnt_valid;

  stack_arb_rr u_arb (
    .CLK       (CLK),
    .RESET     (RESET),
    .req       (req),
    .advance   (take),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  // winner's request fields and their legality against the current occupancy
  always_comb begin
    sel_cmd   = gnt_id ? cmd_e'(cmd1) : cmd_e'(cmd0);
    sel_idx   = gnt_id ? idx1 : idx0;
    sel_wdata = gnt_id ? wdata1 : wdata0;
    sel_legal = 1'b1;
    case (sel_cmd)
      CMD_PUSH: sel_legal = (count_q < DEPTH_C);
      CMD_POP:  sel_legal = (count_q != '0);
      CMD_GET:  sel_legal = (sel_idx < count_q);
      default:  sel_legal = 1'b1;
    endcase
  end

  // state register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  // next state and stack/client drive; the stack sees a command only in ISSUE
  always_comb begin
    state_next   = state;
    stk_cmd      = CMD_NOP;
    stk_index    = '0;
    stk_wdata    = '0;
    stk_wdata_oe = 1'b0;
    ack          = 2'b00;
    err          = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_valid) begin
          if (sel_legal && (sel_cmd != CMD_NOP)) state_next = ISSUE;
          else                                   state_next = RESP;
        end
      end
      ISSUE: begin
        stk_cmd = lat_cmd;
        if (lat_cmd == CMD_GET) stk_index = lat_idx;
        if (lat_cmd == CMD_PUSH) begin
          stk_wdata    = lat_wdata;
          stk_wdata_oe = 1'b1;
        end
        state_next = RESP;
      end
      RESP: begin
        ack        = lat_id ? 2'b10 : 2'b01;
        err        = err_q;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // latch the granted request so later client changes cannot disturb it
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      lat_id    <= 1'b0;
      lat_cmd   <= CMD_NOP;
      lat_idx   <= '0;
      lat_wdata <= '0;
      err_q     <= 1'b0;
    end else if (take) begin
      lat_id    <= gnt_id;
      lat_cmd   <= sel_cmd;
      lat_idx   <= sel_idx;
      lat_wdata <= sel_wdata;
      err_q     <= ~sel_legal;
    end
  end

  // response data: cleared at grant, loaded from the stack at the end of a pop/get ISSUE
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rdata_q <= '0;
    end else if (take) begin
      rdata_q <= '0;
    end else if ((state == ISSUE) && ((lat_cmd == CMD_POP) || (lat_cmd == CMD_GET))) begin
      rdata_q <= stk_rdata;
    end
  end

  // occupancy tracks only commands that actually reached the stack
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count_q <= '0;
    end else if (state == ISSUE) begin
      if (lat_cmd == CMD_PUSH)     count_q <= count_q + ONE_C;
      else if (lat_cmd == CMD_POP) count_q <= count_q - ONE_C;
    end
  end

  assign rdata = rdata_q;
  assign count = count_q;
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

endmodule

// File: tb/tb_stack_arbiter.sv
// tb/tb_stack_arbiter.sv - self-checking bench for stack_arbiter with a behavioural stack and reference model
module tb_stack_arbiter;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [1:0] req = 2'b00;
  logic [1:0] cmd0 = 2'b00, cmd1 = 2'b00;
  logic [2:0] idx0 = 3'd0, idx1 = 3'd0;
  logic [3:0] wdata0 = 4'd0, wdata1 = 4'd0;
  logic [1:0] ack;
  logic       err;
  logic [3:0] rdata;
  logic [1:0] stk_cmd;
  logic [2:0] stk_index;
  logic [3:0] stk_wdata;
  logic       stk_wdata_oe;
  logic [3:0] stk_rdata = 4'd0;
  logic [2:0] count;
  logic       full, empty;

  int n_pass = 0;
  int n_total = 0;
  int last_gnt = 1;
  logic [3:0] ref_q[$];
  logic [3:0] dev[$];

  stack_arbiter dut (
    .CLK(CLK), .RESET(RESET), .req(req),
    .cmd0(cmd0), .cmd1(cmd1), .idx0(idx0), .idx1(idx1),
    .wdata0(wdata0), .wdata1(wdata1),
    .ack(ack), .err(err), .rdata(rdata),
    .stk_cmd(stk_cmd), .stk_index(stk_index), .stk_wdata(stk_wdata),
    .stk_wdata_oe(stk_wdata_oe), .stk_rdata(stk_rdata),
    .count(count), .full(full), .empty(empty)
  );

  always #5 CLK = ~CLK;

  // behavioural stack device: answers and applies commands seen mid-cycle
  always @(negedge CLK) begin
    stk_rdata = 4'd0;
    if (RESET) begin
      dev.delete();
    end else begin
      case (stk_cmd)
        2'b01: dev.push_front(stk_wdata);
        2'b10: if (dev.size() > 0) begin
          stk_rdata = dev[0];
          void'(dev.pop_front());
        end
        2'b11: if (int'(stk_index) < dev.size()) stk_rdata = dev[stk_index];
        default: ;
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"}, ack, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_rdata"}, rdata, 0);
    check({tag, "_stk_cmd"}, stk_cmd, 0);
    check({tag, "_stk_index"}, stk_index, 0);
    check({tag, "_stk_wdata"}, stk_wdata, 0);
    check({tag, "_oe"}, stk_wdata_oe, 0);
    check({tag, "_count"}, count, 0);
    check({tag, "_empty"}, empty, 1);
    check({tag, "_full"}, full, 0);
  endtask

  task automatic apply_reset();
    RESET = 1'b1;
    req = 2'b00;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    ref_q.delete();
    last_gnt = 1;
    @(negedge CLK);
  endtask

  // one client transaction checked against the stack-as-queue model
  task automatic do_op(input int c, input logic [1:0] cm, input logic [2:0] ix,
                       input logic [3:0] wd, input string tag);
    bit legal;
    bit access;
    int sz;
    int cyc;
    bit got;
    logic [3:0] exp_rd;
    sz = ref_q.size();
    case (cm)
      2'b01:   legal = (sz < 5);
      2'b10:   legal = (sz > 0);
      2'b11:   legal = (int'(ix) < sz);
      default: legal = 1'b1;
    endcase
    access = legal && (cm != 2'b00);
    exp_rd = 4'd0;
    if (legal && cm == 2'b10) exp_rd = ref_q[0];
    if (legal && cm == 2'b11) exp_rd = ref_q[ix];
    if (c == 0) begin
      cmd0 = cm; idx0 = ix; wdata0 = wd; req = 2'b01;
    end else begin
      cmd1 = cm; idx1 = ix; wdata1 = wd; req = 2'b10;
    end
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 10) begin
      @(negedge CLK);
      cyc++;
      if (ack != 2'b00) begin
        got = 1'b1;
      end else begin
        check({tag, "_stk_cmd"}, stk_cmd, (access && cyc == 1) ? cm : 2'b00);
        check({tag, "_oe"}, stk_wdata_oe, (access && cyc == 1 && cm == 2'b01) ? 1 : 0);
        if (access && cyc == 1 && cm == 2'b01) check({tag, "_stk_wdata"}, stk_wdata, wd);
        if (access && cyc == 1 && cm == 2'b11) check({tag, "_stk_index"}, stk_index, ix);
      end
    end
    check({tag, "_ack_seen"}, got, 1);
    if (got) begin
      check({tag, "_ack"}, ack, (c == 0) ? 2'b01 : 2'b10);
      check({tag, "_err"}, err, legal ? 0 : 1);
      check({tag, "_rdata"}, rdata, exp_rd);
      check({tag, "_latency"}, cyc, access ? 2 : 1);
    end
    if (legal && cm == 2'b01) ref_q.push_front(wd);
    if (legal && cm == 2'b10) void'(ref_q.pop_front());
    last_gnt = c;
    check({tag, "_count"}, count, ref_q.size());
    check({tag, "_full"}, full, (ref_q.size() == 5) ? 1 : 0);
    check({tag, "_empty"}, empty, (ref_q.size() == 0) ? 1 : 0);
    req = 2'b00;
    @(negedge CLK);
  endtask

  // both clients hold nop requests; winner order follows the arbitration rule
  task automatic both_req(input int nacks);
    int got;
    int cyc;
    int exp_id;
    cmd0 = 2'b00;
    cmd1 = 2'b00;
    req = 2'b11;
    got = 0;
    cyc = 0;
    while (got < nacks && cyc < 100) begin
      @(negedge CLK);
      cyc++;
      if (ack != 2'b00) begin
`ifdef STACK_ARB_RR_EN
        exp_id = (last_gnt == 0) ? 1 : 0;
`else
        exp_id = 0;
`endif
        check("arb_ack", ack, (exp_id == 0) ? 2'b01 : 2'b10);
        check("arb_err", err, 0);
        last_gnt = ack[1] ? 1 : 0;
        got++;
      end
    end
    check("arb_ack_count", got, nacks);
    req = 2'b00;
    @(negedge CLK);
  endtask

  initial begin
    #1;
    check_reset_outputs("reset");
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);

    do_op(0, 2'b01, 3'd0, 4'hA, "push_a");
    do_op(0, 2'b01, 3'd0, 4'h3, "push_3");
    do_op(0, 2'b10, 3'd0, 4'h0, "pop_3");
    do_op(0, 2'b10, 3'd0, 4'h0, "pop_a");
    do_op(0, 2'b10, 3'd0, 4'h0, "pop_empty");
    do_op(1, 2'b00, 3'd0, 4'h0, "nop_c1");

    do_op(0, 2'b01, 3'd0, 4'h7, "push_7");
    do_op(1, 2'b01, 3'd0, 4'h9, "push_9");
    do_op(0, 2'b10, 3'd0, 4'h0, "pop_9");
    do_op(1, 2'b10, 3'd0, 4'h0, "pop_7");

    for (int i = 1; i <= 5; i++) do_op(0, 2'b01, 3'd0, 4'(i), "fill");
    do_op(0, 2'b01, 3'd0, 4'h6, "push_full");
    do_op(1, 2'b11, 3'd4, 4'h0, "get_4");
    do_op(1, 2'b11, 3'd5, 4'h0, "get_5");
    do_op(0, 2'b11, 3'd0, 4'h0, "get_0");

    both_req(6);

    for (int i = 0; i < 40; i++) begin
      int c;
      int cm;
      int ix;
      c  = $urandom_range(0, 1);
      cm = $urandom_range(0, 3);
      ix = (($urandom_range(0, 3) == 0) || ref_q.size() == 0) ? $urandom_range(0, 7)
                                                              : $urandom_range(0, ref_q.size() - 1);
      do_op(c, 2'(cm), 3'(ix), 4'($urandom), "rand");
    end

    both_req(4);

    apply_reset();
    check_reset_outputs("reset2");
    do_op(0, 2'b01, 3'd0, 4'h1, "pre_push1");
    do_op(1, 2'b01, 3'd0, 4'h2, "pre_push2");
    do_op(0, 2'b01, 3'd0, 4'h3, "pre_push3");
    cmd0 = 2'b01;
    wdata0 = 4'hC;
    req = 2'b01;
    @(negedge CLK);
    check("issue_cmd", stk_cmd, 2'b01);
    check("issue_oe", stk_wdata_oe, 1);
    RESET = 1'b1;
    #1;
    check_reset_outputs("abort");
    req = 2'b00;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    ref_q.delete();
    last_gnt = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("abort_no_ack", ack, 0);
    end
    do_op(0, 2'b10, 3'd0, 4'h0, "post_abort_pop");
    do_op(1, 2'b01, 3'd0, 4'h5, "post_abort_push");
    do_op(0, 2'b11, 3'd0, 4'h0, "post_abort_get");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
